acq_uart_framer: RTL and testbench

Downstream stage of the acquisition block: pops one packed 3×16-bit word set from the acquisition BRAM using the `rd_clk` read strobe, then serialises it as a fixed 8-byte UART frame: header, six data bytes, XOR checksum. It runs continuously while `begin_acq` is high and the acquisition buffer reports data available, and is the only consumer of `data_out_1..3`.

---
 rtl/acq_uart_framer_pkg.sv | 6 +
 rtl/acq_uart_framer_if.sv | 7 +
 rtl/acq_uart_framer_uart_tx_byte.sv | 42 ++++
 rtl/acq_uart_framer.sv | 82 ++++++++
 tb/tb_acq_uart_framer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/acq_uart_framer_pkg.sv
// acq_uart_framer_pkg: shared FSM encoding and frame constants for the UART framer
package acq_uart_framer_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DRAIN} state_t;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int FRAME_BYTES = 8;
endpackage

// File: rtl/acq_uart_framer_if.sv
// acq_uart_framer_if: acquisition-side read bus between the BRAM buffer and the framer
interface acq_uart_framer_if;
  logic begin_acq, BRAM_empty, rd_clk;
  logic [15:0] data_in_1, data_in_2, data_in_3;
  modport master (output begin_acq, BRAM_empty, data_in_1, data_in_2, data_in_3, input rd_clk);
  modport slave (input begin_acq, BRAM_empty, data_in_1, data_in_2, data_in_3, output rd_clk);
endinterface

// File: rtl/acq_uart_framer_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter; a start on the final stop-bit cycle chains bytes with no gap
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  logic [TW-1:0] timer;
  logic [3:0] idx;
  logic [7:0] sh;
  logic active;
  assign done = active && idx == 4'd9 && timer == TMAX;
  // idx is the bit on the line: 0 start, 1..8 data, 9 stop
  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= 1'b1;
      active <= 1'b0;
      timer <= '0;
      idx <= '0;
      sh <= '0;
    end else if (start) begin
      tx <= 1'b0;
      active <= 1'b1;
      timer <= '0;
      idx <= '0;
      sh <= data;
    end else if (active) begin
      timer <= timer == TMAX ? '0 : timer + TW'(1);
      if (timer == TMAX) begin
        idx <= idx == 4'd9 ? 4'd0 : idx + 4'd1;
        active <= idx != 4'd9;
        tx <= idx >= 4'd8 || sh[idx[2:0]];
      end
    end
  end
endmodule

// File: rtl/acq_uart_framer.sv
// acq_uart_framer: pops one 3x16-bit word set per frame and sends HEADER, six data bytes, XOR checksum
module acq_uart_framer
  import acq_uart_framer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_WAIT = 4,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic clk,
  input  logic reset,
  acq_uart_framer_if.slave acq,
  output logic uart_tx,
  output logic busy,
  output logic [15:0] frames_sent
);
  state_t state, nxt;
  logic [15:0] cnt;
  logic [2:0] bidx, sel;
  logic [47:0] f;
  logic [63:0] fr;
  logic [7:0] chk, byte_d;
  logic start, done, cap, inc;
  assign chk = f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
  assign fr = {HEADER, f, chk};
  assign sel = state == SEND ? 3'(bidx + 3'd1) : 3'd0;
  assign byte_d = fr[{~sel, 3'b000} +: 8];
  always_comb begin
    nxt = state;
    start = 1'b0;
    cap = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE: if (acq.begin_acq && !acq.BRAM_empty) nxt = REQ;
      REQ: nxt = acq.begin_acq ? WAIT : IDLE;
      WAIT:
        if (!acq.begin_acq) nxt = IDLE;
        else if (cnt == 16'(DATA_WAIT - 1)) begin
          nxt = SEND;
          cap = 1'b1;
          start = 1'b1;
        end
      SEND:
        if (done) begin
          if (bidx == 3'(FRAME_BYTES - 1)) begin
            nxt = IDLE;
            inc = 1'b1;
          end else if (!acq.begin_acq) nxt = DRAIN;
          else start = 1'b1;
        end
      DRAIN: if (cnt == 16'(CLKS_PER_BIT - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // cnt restarts on every state entry, timing both WAIT and DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bidx <= '0;
      f <= '0;
      frames_sent <= '0;
      acq.rd_clk <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? 16'd0 : cnt + 16'd1;
      bidx <= start ? sel : bidx;
      if (cap) f <= {acq.data_in_1, acq.data_in_2, acq.data_in_3};
      frames_sent <= frames_sent + 16'(inc);
      acq.rd_clk <= nxt == REQ;
      busy <= nxt != IDLE;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data(byte_d),
    .tx(uart_tx),
    .done(done)
  );
endmodule

// File: tb/tb_acq_uart_framer.sv
// tb_acq_uart_framer: random word sets checked against a line decoder and a frame-level reference
module tb_acq_uart_framer;
  import acq_uart_framer_pkg::*;
  localparam int CPB = 4, DW = 4, BYTE_T = 10 * CPB, FRAME_T = 80 * CPB;
  typedef struct {logic [7:0] b; logic stop; int t;} rx_t;
  logic clk = 1'b0, rst = 1'b1, uart_tx, busy;
  logic [15:0] frames_sent;
  int cyc = 0, errors = 0, checks = 0, dbl = 0, bad, c, x, exp_frames;
  rx_t rx[$];
  int strobes[$];
  logic [47:0] exp_words[$];
  logic use_fixed = 1'b0;
  logic [47:0] fixed_w = '0, acq_w;
  logic [7:0] dec_b;
  int dec_t;
  acq_uart_framer_if acq();
  acq_uart_framer #(.CLKS_PER_BIT(CPB), .DATA_WAIT(DW), .HEADER(DEFAULT_HEADER)) dut (
    .clk(clk), .reset(rst), .acq(acq), .uart_tx(uart_tx), .busy(busy), .frames_sent(frames_sent)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [47:0] w, input int k);
    logic [7:0] d [6];
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 6; i++) begin
      d[i] = w[47 - 8 * i -: 8];
      s ^= d[i];
    end
    if (k == 0) return DEFAULT_HEADER;
    if (k == 7) return s;
    return d[k - 1];
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_strobes(input int n);
    int lim = 0;
    while (strobes.size() < n && lim < 2000) begin
      @(negedge clk);
      lim++;
    end
    check("strobe_count", strobes.size(), n);
  endtask

  task automatic expect_frame(input int cs, input int nb);
    logic [47:0] w;
    rx_t e;
    int lim = 0;
    while (rx.size() < nb && lim < FRAME_T + 100) begin
      @(negedge clk);
      lim++;
    end
    check("rx_count", rx.size(), nb);
    w = exp_words.size() > 0 ? exp_words.pop_front() : '0;
    for (int k = 0; k < nb && rx.size() > 0; k++) begin
      e = rx.pop_front();
      check($sformatf("byte%0d", k), int'(e.b), int'(ref_byte(w, k)));
      check($sformatf("stop%0d", k), int'(e.stop), 1);
      check($sformatf("start_cyc%0d", k), e.t, cs + DW + 2 + k * BYTE_T);
    end
  endtask

  always @(negedge clk)
    if (acq.rd_clk === 1'b1) begin
      if (strobes.size() > 0 && strobes[$] == cyc - 1) dbl++;
      strobes.push_back(cyc);
    end

  // acquisition stand-in: presents a word set after each strobe, then scrambles it once captured
  initial begin
    {acq.data_in_1, acq.data_in_2, acq.data_in_3} = '0;
    forever begin
      @(negedge clk);
      if (acq.rd_clk === 1'b1) begin
        acq_w = use_fixed ? fixed_w : 48'({$urandom, $urandom});
        {acq.data_in_1, acq.data_in_2, acq.data_in_3} = acq_w;
        exp_words.push_back(acq_w);
        repeat (DW + 1) @(negedge clk);
        {acq.data_in_1, acq.data_in_2, acq.data_in_3} = 48'({$urandom, $urandom});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      dec_t = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        dec_b[k] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      rx.push_back('{dec_b, uart_tx, dec_t});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    acq.begin_acq = 1'b0;
    acq.BRAM_empty = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", int'(uart_tx), 1);
    check("rst_rd_clk", int'(acq.rd_clk), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frames", int'(frames_sent), 0);
    use_fixed = 1'b1;
    fixed_w = 48'h147A_258B_369C;
    acq.begin_acq = 1'b1;
    acq.BRAM_empty = 1'b0;
    wait_strobes(1);
    c = strobes[0] - 1;
    acq.BRAM_empty = 1'b1;
    wait_until(c + 2);
    check("rd_clk_single", int'(acq.rd_clk), 0);
    check("busy_after_strobe", int'(busy), 1);
    expect_frame(c, 8);
    wait_until(c + DW + 1 + FRAME_T);
    check("busy_last_stop", int'(busy), 1);
    wait_until(c + DW + 2 + FRAME_T);
    check("busy_fall", int'(busy), 0);
    check("frames_basic", int'(frames_sent), 1);
    exp_frames = 1;
    use_fixed = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      bad += int'(acq.rd_clk !== 1'b0 || uart_tx !== 1'b1 || busy !== 1'b0);
    end
    check("holdoff_idle", bad, 0);
    check("holdoff_strobes", strobes.size(), 1);
    x = cyc;
    acq.BRAM_empty = 1'b0;
    wait_strobes(2);
    check("holdoff_release", int'(strobes[1] - x >= 1 && strobes[1] - x <= 2), 1);
    for (int f = 0; f < 3; f++) begin
      wait_strobes(2 + f);
      c = strobes[1 + f] - 1;
      if (f == 2) acq.BRAM_empty = 1'b1;
      expect_frame(c, 8);
    end
    wait_until(c + DW + 2 + FRAME_T + 20);
    exp_frames += 3;
    check("frames_b2b", int'(frames_sent), exp_frames);
    check("b2b_strobes", strobes.size(), 4);
    for (int i = 1; i < 3; i++)
      check("strobe_gap", int'(strobes[i + 1] - strobes[i] >= FRAME_T + DW + 2), 1);
    acq.BRAM_empty = 1'b0;
    wait_strobes(5);
    c = strobes[4] - 1;
    acq.BRAM_empty = 1'b1;
    wait_until(c + DW + 2 + 3 * BYTE_T + 14);
    acq.begin_acq = 1'b0;
    expect_frame(c, 4);
    x = c + DW + 2 + 4 * BYTE_T;
    wait_until(x + CPB - 1);
    check("drain_busy", int'(busy), 1);
    wait_until(x + CPB);
    check("abort_idle", int'(busy), 0);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      bad += int'(uart_tx !== 1'b1 || busy !== 1'b0);
    end
    check("abort_line_high", bad, 0);
    check("abort_no_byte4", rx.size(), 0);
    check("abort_frames", int'(frames_sent), exp_frames);
    check("abort_strobes", strobes.size(), 5);
    acq.begin_acq = 1'b1;
    acq.BRAM_empty = 1'b0;
    wait_strobes(6);
    c = strobes[5] - 1;
    acq.BRAM_empty = 1'b1;
    wait_until(c + DW + 2 + 5 * BYTE_T + 15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx", int'(uart_tx), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_frames", int'(frames_sent), 0);
    exp_frames = 0;
    repeat (60) @(negedge clk);
    rx.delete();
    exp_words.delete();
    acq.BRAM_empty = 1'b0;
    wait_strobes(7);
    c = strobes[6] - 1;
    acq.BRAM_empty = 1'b1;
    expect_frame(c, 8);
    wait_until(c + DW + 2 + FRAME_T);
    exp_frames++;
    check("frames_after_rst", int'(frames_sent), exp_frames);
    check("rd_clk_consecutive", dbl, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
